// File: rtl/count_snapshot_buffer.sv
// Watches a modulo-N count, keeps a saturating wrap tally, and queues
// {tally, count} snapshots in a first-word fall-through FIFO drained by valid/ready.
module count_snapshot_buffer #(
    parameter int N      = 32,
    parameter int WRAP_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [$clog2(N)-1:0]             count_in,
    input  logic                             capture,
    input  logic                             clear,
    output logic                             snap_valid,
    input  logic                             snap_ready,
    output logic [WRAP_W+$clog2(N)-1:0]      snap_data,
    output logic                             wrap_pulse,
    output logic [WRAP_W-1:0]                wrap_count,
    output logic                             overflow,
    output logic [$clog2(DEPTH):0]           level
);

    localparam int CW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WRAP_W + CW;

    logic [CW-1:0]     prev_count_q;
    logic              prev_valid_q;
    logic              wrap_pulse_q;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              overflow_q, overflow_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]     mem_q [DEPTH];

    logic wrap_det;
    logic push;
    logic pop;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        wrap_det = prev_valid_q && (prev_count_q == CW'(N - 1)) && (count_in == '0);
        pop      = (level_q != '0) && snap_ready;
        push     = capture && ((level_q < LW'(DEPTH)) || pop);

        // clear wins over a coincident wrap or dropped capture
        wrap_count_d = wrap_count_q;
        overflow_d   = overflow_q;
        if (clear) begin
            wrap_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (wrap_det)
                wrap_count_d = sat_inc(wrap_count_q);
            if (capture && !push)
                overflow_d = 1'b1;
        end

        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_count_q <= '0;
            prev_valid_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            overflow_q   <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            prev_count_q <= count_in;
            prev_valid_q <= 1'b1;
            wrap_pulse_q <= wrap_det;
            wrap_count_q <= wrap_count_d;
            overflow_q   <= overflow_d;
            level_q      <= level_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; an empty FIFO masks its contents at the output.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {wrap_count_q, count_in};
    end

    assign snap_valid = (level_q != '0);
    assign snap_data  = snap_valid ? mem_q[rd_ptr_q] : '0;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign overflow   = overflow_q;
    assign level      = level_q;

endmodule

// File: doc/count_snapshot_buffer.md
Name: count_snapshot_buffer

Overview:
- Downstream consumer of the modulo-N counter output.
- Watches the incoming count, detects wrap-around (N-1 -> 0) and keeps a saturating wrap tally.
- On a capture request, it stores {wrap tally, count} snapshots in a small FIFO.
- The FIFO drains through a valid/ready interface to the register/readout logic.

Parameters:
- N, 32, modulus of the upstream counter; count width CW = $clog2(N).
- WRAP_W, 8, width of the saturating wrap tally.
- DEPTH, 4, FIFO entries; must be a power of two and >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- count_in  input  CW  count value from the upstream counter.
- capture  input  1  snapshot request, sampled every edge.
- clear  input  1  synchronous clear of wrap_count and overflow.
- snap_valid  output  1  FIFO non-empty.
- snap_ready  input  1  consumer accepts head entry.
- snap_data  output  WRAP_W+CW  head entry, {wrap tally, count}.
- wrap_pulse  output  1  one-cycle registered wrap indication.
- wrap_count  output  WRAP_W  saturating wrap tally.
- overflow  output  1  sticky: a capture was dropped.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - wrap_pulse=0, wrap_count=0, overflow=0, level=0, snap_valid=0.
  - snap_data=0; FIFO pointers=0; prev_count=0; prev_valid=0.
- Wrap detection:
  - prev_count <= count_in every edge; prev_valid <= 1 on the first edge after reset.
  - wrap_pulse <= prev_valid && prev_count==N-1 && count_in==0.
  - wrap_pulse is visible the cycle after count_in==0 is presented; it lasts exactly one cycle.
  - Any other transition (e.g. N-1 -> 3, 0 -> 0, hold at N-1) does not raise wrap_pulse.
  - The first sample after reset never wraps.
- wrap_count:
  - Increments by 1 on each edge that sets wrap_pulse.
  - Saturates at 2^WRAP_W-1 and never rolls over.
  - clear has priority: if clear and a wrap occur on the same edge, the result is 0.
- Snapshot entry:
  - Entry = {wrap_count as registered before this edge, count_in at this edge}.
  - A same-edge wrap increment is not included in that entry.
- FIFO (first-word fall-through):
  - pop = snap_valid && snap_ready.
  - push = capture && (level<DEPTH || pop).
  - snap_data shows the head entry combinationally from storage; snap_data=0 when empty.
  - Push on an empty FIFO: snap_valid=1 and the entry appears on the next cycle (latency 1).
  - Simultaneous push and pop: level unchanged, including when full.
  - Pop when empty: ignored.
  - level is exact, 0..DEPTH; pointers wrap modulo DEPTH.
- Overflow:
  - capture while level==DEPTH and no pop: entry dropped, overflow <= 1.
  - overflow stays sticky until clear or reset.
  - clear does not flush the FIFO.
- Handshake:
  - While snap_valid=1 and snap_ready=0, snap_data must be stable.
  - snap_valid does not drop without a pop.
- Reset mid-operation: all FIFO contents, the tally and the flags are discarded immediately on reset_n low, regardless of clk.

Test Plan:
- All tests use N=8 (CW=3), WRAP_W=4, DEPTH=4.
- Reset: assert reset_n=0 mid-cycle with FIFO holding 2 entries -> all outputs 0 immediately, snap_valid=0, level=0; after release, count_in 7 then 0 gives no wrap_pulse.
- Wrap detection: drive count_in 0,1,...,7,0,1 -> wrap_pulse high exactly one cycle after the 0 sample, wrap_count=1. Then drive 7,3 and 7,7,0 -> only the 7->0 raises a pulse, wrap_count=2.
- Capture:
  - With wrap_count=2, pulse capture at count_in=5 -> next cycle snap_valid=1, snap_data=7'h15, level=1.
  - snap_ready=1 for one cycle -> snap_valid=0, level=0.
- Full/overflow:
  - snap_ready=0, capture on 5 consecutive cycles with count_in=1..5 -> level=4, overflow=1.
  - Drain yields counts 1,2,3,4 in order; entry 5 is absent.
  - clear -> overflow=0, wrap_count=0, FIFO contents untouched.
- Full with simultaneous push/pop: level=4, capture with count_in=6 and snap_ready=1 on the same edge -> level stays 4, overflow stays 0, and the 6 entry drains last.
- Saturation/priority:
  - 20 wraps -> wrap_count=15, no rollover.
  - Capture on the same edge as the 16th wrap stores tally 15.
  - clear coincident with a wrap -> wrap_count=0.
